debug_tx_serializer: RTL and testbench
======================================

DEBUG_TX_SERIALIZER -- requirements
Module: debug_tx_serializer

Interface
REQ-001 Parameter LSB_FIRST, default 0: 0 sends the most significant selected byte first; 1 sends the least significant byte first.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum cycles spent in any wait state before abort.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  one-cycle strobe; result/size from the debug decoder are valid.
REQ-006 result  input  32  response word.
REQ-007 size  input  2  byte count minus one (00 = 1 byte, 11 = 4 bytes).
REQ-008 tx_ready  input  1  UART transmitter idle and able to accept a byte.
REQ-009 tx_data  output  8  byte presented to the UART.
REQ-010 tx_start  output  1  one-cycle pulse; UART latches tx_data.
REQ-011 busy  output  1  high from capture until return to IDLE.
REQ-012 done  output  1  one-cycle pulse after the last byte completes.
REQ-013 timeout  output  1  one-cycle pulse on abort.
REQ-014 overrun  output  1  sticky; set when cmd_valid arrives while busy.

Function
REQ-015 FSM states: IDLE, SEND, WAIT_LOW, WAIT_HIGH, FINISH.
REQ-016 IDLE and cmd_valid=1: capture result into shift_reg, size+1 into a 3-bit byte counter, set busy, go to SEND on the next cycle.
REQ-017 SEND and tx_ready=1: drive tx_data with the current byte, pulse tx_start, decrement the counter, shift shift_reg by 8 bits, go to WAIT_LOW.
REQ-018 SEND and tx_ready=0: hold in SEND, tx_start=0.
REQ-019 Byte selection: LSB_FIRST=0 takes byte index size first and descends to 0; LSB_FIRST=1 takes byte 0 first and ascends to size. Bytes above size are never sent.
REQ-020 WAIT_LOW: go to WAIT_HIGH when tx_ready=0.
REQ-021 WAIT_HIGH: when tx_ready=1, go to SEND if counter is nonzero, otherwise go to FINISH.
REQ-022 FINISH: pulse done for one cycle, clear busy, go to IDLE.
REQ-023 Latency: the first tx_start occurs 1 cycle after cmd_valid if tx_ready=1.
REQ-024 Each byte requires an observed high-to-low-to-high transition of tx_ready; a UART that never drops ready therefore times out.
REQ-025 Timeout counter: cleared on every state change. If it reaches TIMEOUT_CYCLES-1 in SEND, WAIT_LOW or WAIT_HIGH, pulse timeout, clear busy, go to IDLE, and do not pulse done.
REQ-026 cmd_valid while not in IDLE is ignored, sets overrun, and leaves the in-flight transfer unchanged.
REQ-027 cmd_valid in the same cycle that FINISH returns to IDLE is treated as an overrun and ignored.
REQ-028 tx_data holds its last value between pulses; it is valid only while tx_start=1.

Reset
REQ-029 reset=1 forces IDLE next cycle: tx_data=0, tx_start=0, busy=0, done=0, timeout=0, overrun=0, shift_reg=0, counter=0, timeout counter=0.
REQ-030 Reset mid-transfer abandons remaining bytes with no done or timeout pulse; reset has priority over cmd_valid.

Structure
REQ-031 Package debug_pkg holds the state encoding, the size-code constants (SZ_BYTE=00, SZ_WORD=11) and the response byte-count width.
REQ-032 Single module, no sub-modules; the timeout counter is inline. The bench supplies a behavioural UART model that drops tx_ready 1 cycle after tx_start and raises it N cycles later.

Verification
REQ-033 size=11, result=0x12345678, LSB_FIRST=0, model N=10 -> tx bytes 12,34,56,78; one done pulse; busy spans the entire transfer.
REQ-034 size=00, result=0xAABBCC55 -> exactly one byte 55, then done.
REQ-035 LSB_FIRST=1, size=01, result=0x0000BEEF -> bytes EF, BE.
REQ-036 cmd_valid pulsed mid-transfer -> overrun=1 and sticky; original byte sequence unaffected.
REQ-037 TIMEOUT_CYCLES=50, tx_ready stuck low -> timeout pulse at cycle 50 of SEND, busy=0, no done.
REQ-038 reset asserted after the 2nd byte of 4 -> all outputs 0 next cycle; a new cmd_valid then transmits normally.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared encodings for the debug response serializer: FSM states,
// response size codes and the width of the remaining-byte counter.
// Pure declarations, no logic.
package debug_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_LOW  = 3'd2,
      ST_WAIT_HIGH = 3'd3,
      ST_FINISH    = 3'd4
   } state_t;

   // size field holds byte count minus one
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_WORD = 2'b11;

   // counts 1..4 remaining bytes, so one spare bit above the size code
   localparam int BCNT_W = 3;

   function automatic logic [BCNT_W-1:0] size_to_count(input logic [1:0] sz);
      return BCNT_W'(sz) + BCNT_W'(1);
   endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Serializes a 1..4 byte debug response onto a byte-wide UART, MSB- or LSB-first.
// Latency: first tx_start one cycle after cmd_valid when tx_ready is already high.
// Backpressure: each byte waits for tx_ready to fall then rise; a stalled UART aborts via timeout.
module debug_tx_serializer
   import debug_pkg::*;
#(
   parameter bit          LSB_FIRST      = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic [31:0] result,
   input  logic [1:0]  size,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        overrun
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       shift_reg;
   logic [BCNT_W-1:0] byte_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [7:0]        tx_data_q;
   logic [7:0]        cur_byte;
   logic [4:0]        align_sh;
   logic              load;
   logic              send;
   logic              tmo_hit;

   // MSB-first: pre-shift so byte[size] sits in the top lane and the
   // unused upper bytes fall off; LSB-first just sends from the bottom lane.
   assign align_sh = {SZ_WORD - size, 3'b000};
   assign cur_byte = LSB_FIRST ? shift_reg[7:0] : shift_reg[31:24];
   assign tmo_hit  = (tmo_cnt == TMO_LAST);
   assign busy     = (state != ST_IDLE);

   // The byte is presented combinationally on the launch cycle, then held.
   assign tx_data  = tx_start ? cur_byte : tx_data_q;

   // Next-state decode and single-cycle strobes; reset suppresses all strobes.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      send      = 1'b0;
      tx_start  = 1'b0;
      done      = 1'b0;
      timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               load      = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tmo_hit) begin
               timeout   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (tx_ready) begin
               send      = 1'b1;
               tx_start  = 1'b1;
               state_nxt = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (tmo_hit) begin
               timeout   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!tx_ready) begin
               state_nxt = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (tmo_hit) begin
               timeout   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (tx_ready) begin
               state_nxt = (byte_cnt != '0) ? ST_SEND : ST_FINISH;
            end
         end
         ST_FINISH: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (reset) begin
         tx_start = 1'b0;
         done     = 1'b0;
         timeout  = 1'b0;
      end
   end

   // State, datapath, dwell timer and sticky overrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         byte_cnt  <= '0;
         tmo_cnt   <= '0;
         tx_data_q <= '0;
         overrun   <= 1'b0;
      end else begin
         state <= state_nxt;

         // timer measures dwell in the current wait state only
         if ((state_nxt != state) || (state == ST_IDLE) || (state == ST_FINISH)) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         if (load) begin
            shift_reg <= LSB_FIRST ? result : (result << align_sh);
            byte_cnt  <= size_to_count(size);
         end else if (send) begin
            shift_reg <= LSB_FIRST ? (shift_reg >> 8) : (shift_reg << 8);
            byte_cnt  <= byte_cnt - 1'b1;
            tx_data_q <= cur_byte;
         end

         // FINISH counts as busy, so a command on the return-to-idle edge is rejected
         if (cmd_valid && (state != ST_IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_debug_tx_serializer.sv
module tb_debug_tx_serializer;
   import debug_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic [31:0] result;
   logic [1:0]  size;

   // index 0: MSB-first instance, index 1: LSB-first instance
   logic        d_tx_ready [2];
   logic [7:0]  d_tx_data  [2];
   logic        d_tx_start [2];
   logic        d_busy     [2];
   logic        d_done     [2];
   logic        d_timeout  [2];
   logic        d_overrun  [2];

   int   n_chk  = 0;
   int   n_fail = 0;
   int   uart_n = 10;
   logic uart_stuck = 1'b0;

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int done_cnt     [2];
   int tmo_cnt      [2];
   int busy_low_evt [2];

   typedef struct {
      logic [31:0] result;
      logic [1:0]  size;
      logic [31:0] exp_msb;   // bytes in send order, first byte in [31:24]
      logic [31:0] exp_lsb;
   } vec_t;
   vec_t vecs [4];

   always #5 clk = ~clk;

   debug_tx_serializer #(.LSB_FIRST(1'b0), .TIMEOUT_CYCLES(50)) u_msb (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .result(result), .size(size),
      .tx_ready(d_tx_ready[0]), .tx_data(d_tx_data[0]), .tx_start(d_tx_start[0]),
      .busy(d_busy[0]), .done(d_done[0]), .timeout(d_timeout[0]), .overrun(d_overrun[0]));

   debug_tx_serializer #(.LSB_FIRST(1'b1), .TIMEOUT_CYCLES(50)) u_lsb (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .result(result), .size(size),
      .tx_ready(d_tx_ready[1]), .tx_data(d_tx_data[1]), .tx_start(d_tx_start[1]),
      .busy(d_busy[1]), .done(d_done[1]), .timeout(d_timeout[1]), .overrun(d_overrun[1]));

   // UART model: ready drops the cycle after tx_start and returns uart_n cycles later
   for (genvar g = 0; g < 2; g++) begin : g_uart
      int ucnt = 0;
      always @(posedge clk) begin
         if (uart_stuck) begin
            d_tx_ready[g] <= 1'b0;
            ucnt          <= 0;
         end else if (reset) begin
            d_tx_ready[g] <= 1'b1;
            ucnt          <= 0;
         end else if (d_tx_start[g]) begin
            d_tx_ready[g] <= 1'b0;
            ucnt          <= uart_n;
         end else if (ucnt > 1) begin
            ucnt <= ucnt - 1;
         end else begin
            ucnt          <= 0;
            d_tx_ready[g] <= 1'b1;
         end
      end
   end

   // capture everything the UARTs would see
   always @(negedge clk) begin
      if (d_tx_start[0]) q0.push_back(d_tx_data[0]);
      if (d_tx_start[1]) q1.push_back(d_tx_data[1]);
      for (int d = 0; d < 2; d++) begin
         if (d_done[d])    done_cnt[d]++;
         if (d_timeout[d]) tmo_cnt[d]++;
         if ((d_tx_start[d] || d_done[d]) && !d_busy[d]) busy_low_evt[d]++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: still running at %0t, limit 500000", $time);
      $fatal(1, "watchdog expired");
   end

   // reference: byte i of the sequence is result byte (lsb ? i : size-i)
   function automatic logic [31:0] model_seq(input logic [31:0] r, input logic [1:0] s, input bit lsb);
      logic [31:0] seq = '0;
      int n = int'(s) + 1;
      for (int i = 0; i < n; i++) begin
         int idx = lsb ? i : (n - 1 - i);
         seq[31 - 8*i -: 8] = r[8*idx +: 8];
      end
      return seq;
   endfunction

   function automatic logic [31:0] got_byte(input int d, input int k);
      if (d == 0) return (k < q0.size()) ? {24'h0, q0[k]} : 32'hFFFF_FFFF;
      return (k < q1.size()) ? {24'h0, q1[k]} : 32'hFFFF_FFFF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
         done_cnt[d]     = 0;
         tmo_cnt[d]      = 0;
         busy_low_evt[d] = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // returns at the negedge of the first cycle after the capture edge
   task automatic issue(input logic [31:0] r, input logic [1:0] s);
      @(negedge clk);
      clear_mon();
      result    = r;
      size      = s;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int cyc = 0;
      while ((d_busy[0] || d_busy[1]) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_idle"}, {31'h0, d_busy[0] | d_busy[1]}, 32'h0);
   endtask

   task automatic check_seq(input string tag, input int d, input logic [1:0] s, input logic [31:0] exp);
      int n  = int'(s) + 1;
      int qs = (d == 0) ? q0.size() : q1.size();
      chk({tag, "_count"}, qs, n);
      for (int k = 0; k < n; k++)
         chk($sformatf("%s_byte%0d", tag, k), got_byte(d, k), {24'h0, exp[31 - 8*k -: 8]});
   endtask

   task automatic xfer(input string tag, input logic [31:0] r, input logic [1:0] s,
                       input logic [31:0] exp0, input logic [31:0] exp1);
      issue(r, s);
      chk({tag, "_lat_msb"}, d_tx_start[0], 1);
      chk({tag, "_lat_lsb"}, d_tx_start[1], 1);
      chk({tag, "_busy_first"}, {31'h0, d_busy[0] & d_busy[1]}, 1);
      wait_idle(tag);
      check_seq({tag, "_msb"}, 0, s, exp0);
      check_seq({tag, "_lsb"}, 1, s, exp1);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_done%0d", tag, d), done_cnt[d], 1);
         chk($sformatf("%s_tmo%0d", tag, d), tmo_cnt[d], 0);
         chk($sformatf("%s_busygap%0d", tag, d), busy_low_evt[d], 0);
      end
   endtask

   initial begin
      int cyc;
      logic [31:0] r;
      logic [1:0]  s;

      vecs[0] = '{32'h1234_5678, SZ_WORD, 32'h1234_5678, 32'h7856_3412};
      vecs[1] = '{32'hAABB_CC55, SZ_BYTE, 32'h5500_0000, 32'h5500_0000};
      vecs[2] = '{32'h0000_BEEF, 2'b01,   32'hBEEF_0000, 32'hEFBE_0000};
      vecs[3] = '{32'hDEAD_BEEF, 2'b10,   32'hADBE_EF00, 32'hEFBE_AD00};

      reset = 1'b1; cmd_valid = 1'b0; result = '0; size = '0;
      clear_mon();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_tx_data%0d", d),  d_tx_data[d],  0);
         chk($sformatf("rst_tx_start%0d", d), d_tx_start[d], 0);
         chk($sformatf("rst_busy%0d", d),     d_busy[d],     0);
         chk($sformatf("rst_done%0d", d),     d_done[d],     0);
         chk($sformatf("rst_timeout%0d", d),  d_timeout[d],  0);
         chk($sformatf("rst_overrun%0d", d),  d_overrun[d],  0);
      end

      // directed table, UART recovers after 10 cycles
      uart_n = 10;
      for (int i = 0; i < 4; i++)
         xfer($sformatf("vec%0d", i), vecs[i].result, vecs[i].size, vecs[i].exp_msb, vecs[i].exp_lsb);

      // command mid-transfer: flagged, ignored, sticky
      issue(32'h1234_5678, SZ_WORD);
      repeat (15) @(negedge clk);
      cmd_valid = 1'b1; result = 32'hFFFF_FFFF; size = SZ_BYTE;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ovr_set_msb", d_overrun[0], 1);
      chk("ovr_set_lsb", d_overrun[1], 1);
      wait_idle("ovr");
      check_seq("ovr_msb", 0, SZ_WORD, vecs[0].exp_msb);
      check_seq("ovr_lsb", 1, SZ_WORD, vecs[0].exp_lsb);
      chk("ovr_done", done_cnt[0], 1);
      xfer("ovr_next", vecs[2].result, vecs[2].size, vecs[2].exp_msb, vecs[2].exp_lsb);
      chk("ovr_sticky_msb", d_overrun[0], 1);
      chk("ovr_sticky_lsb", d_overrun[1], 1);

      // command in the FINISH cycle is rejected as an overrun
      do_reset();
      uart_n = 3;
      chk("fin_ovr_clear", d_overrun[0], 0);
      issue(32'hAABB_CC55, SZ_BYTE);
      cyc = 0;
      while (!d_done[0] && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("fin_done_seen", d_done[0], 1);
      cmd_valid = 1'b1; result = 32'h0102_0304; size = SZ_WORD;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("fin_busy_msb", d_busy[0], 0);
      chk("fin_busy_lsb", d_busy[1], 0);
      chk("fin_ovr_msb", d_overrun[0], 1);
      chk("fin_ovr_lsb", d_overrun[1], 1);
      repeat (3) @(negedge clk);
      chk("fin_still_idle", {31'h0, d_busy[0] | d_busy[1]}, 0);
      chk("fin_bytes", q0.size(), 1);

      // UART never ready: abort at the 50th SEND cycle without done
      uart_stuck = 1'b1;
      repeat (3) @(negedge clk);
      issue(32'h0102_0304, SZ_WORD);
      repeat (48) @(negedge clk);
      chk("tmo_early_msb", d_timeout[0], 0);
      chk("tmo_early_lsb", d_timeout[1], 0);
      @(negedge clk);
      chk("tmo_pulse_msb", d_timeout[0], 1);
      chk("tmo_pulse_lsb", d_timeout[1], 1);
      chk("tmo_busy_during", d_busy[0], 1);
      @(negedge clk);
      chk("tmo_pulse_end", d_timeout[0], 0);
      chk("tmo_busy_after_msb", d_busy[0], 0);
      chk("tmo_busy_after_lsb", d_busy[1], 0);
      chk("tmo_no_done", done_cnt[0] + done_cnt[1], 0);
      chk("tmo_count", tmo_cnt[0], 1);
      chk("tmo_no_bytes", q0.size() + q1.size(), 0);
      uart_stuck = 1'b0;
      repeat (3) @(negedge clk);

      // reset after the second of four bytes
      uart_n = 10;
      issue(32'h1234_5678, SZ_WORD);
      cyc = 0;
      while (q0.size() < 2 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("mrst_tx_data%0d", d),  d_tx_data[d],  0);
         chk($sformatf("mrst_tx_start%0d", d), d_tx_start[d], 0);
         chk($sformatf("mrst_busy%0d", d),     d_busy[d],     0);
         chk($sformatf("mrst_done%0d", d),     d_done[d],     0);
         chk($sformatf("mrst_timeout%0d", d),  d_timeout[d],  0);
         chk($sformatf("mrst_overrun%0d", d),  d_overrun[d],  0);
      end
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("mrst_bytes", q0.size(), 2);
      chk("mrst_no_done", done_cnt[0] + done_cnt[1], 0);
      chk("mrst_no_tmo", tmo_cnt[0] + tmo_cnt[1], 0);
      xfer("mrst_next", vecs[0].result, vecs[0].size, vecs[0].exp_msb, vecs[0].exp_lsb);

      // randomized responses and UART recovery times
      for (int i = 0; i < 20; i++) begin
         r      = $urandom;
         s      = 2'($urandom_range(0, 3));
         uart_n = $urandom_range(1, 8);
         xfer($sformatf("rnd%0d", i), r, s, model_seq(r, s, 1'b0), model_seq(r, s, 1'b1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
